counter16_core: RTL and testbench

Programmable 16-bit timer/counter core that sits directly downstream of the prescaler. It consumes the prescaler's one-cycle `o_sclk_rise` strobe as its count tick and counts up or down in free-run, auto-reload or one-shot mode. It raises sticky overflow and compare-match flags for the register/interrupt layer above it.

---
 rtl/counter16_core.sv | 147 ++++++++++++++
 tb/tb_counter16_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter16_core.sv
// rtl/counter16_core.sv - 16-bit up/down timer/counter with reload, compare and optional capture (COUNTER16_CAPTURE_EN)
module counter16_core #(
    parameter int WIDTH = 16
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    input  logic             i_module_en,
    input  logic             i_tick,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic             i_cmp_ld,
    input  logic [WIDTH-1:0] i_cmp_data,
    input  logic [1:0]       i_mode,
    input  logic             i_dir,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_flag_clr,
    input  logic             i_capture,
    output logic [WIDTH-1:0] o_count,
    output logic             o_running,
    output logic             o_ovf,
    output logic             o_ovf_pulse,
    output logic             o_cmp_match,
    output logic [WIDTH-1:0] o_capture_data,
    output logic             o_capture_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count, reload, cmp, count_step, tc;
    logic             counted, at_tc, reload_mode, one_shot;

    assign o_count     = count;
    assign o_running   = (state == RUN);
    assign one_shot    = (i_mode == 2'b10);
    assign reload_mode = (i_mode == 2'b01) || one_shot;
    assign tc          = i_dir ? '0 : '1;
    assign at_tc       = (count == tc);
    // A load in the same cycle swallows the tick entirely.
    assign counted     = (state == RUN) && i_module_en && i_tick && !i_ld;

    // Free-run wrap falls out of modular +/-1; only reload modes override.
    always_comb begin
        count_step = i_dir ? (count - WIDTH'(1)) : (count + WIDTH'(1));
        if (at_tc && reload_mode)
            count_step = reload;
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_module_en) begin
            case (state)
                IDLE: if (!i_stop && i_start) state_nxt = RUN;
                RUN: begin
                    if (i_stop)
                        state_nxt = IDLE;
                    else if (counted && at_tc && one_shot)
                        state_nxt = DONE;
                end
                DONE: begin
                    if (i_stop)
                        state_nxt = IDLE;
                    else if (i_start)
                        state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            count       <= '0;
            reload      <= '0;
            cmp         <= '0;
            o_ovf       <= 1'b0;
            o_ovf_pulse <= 1'b0;
            o_cmp_match <= 1'b0;
        end else begin
            o_ovf_pulse <= 1'b0;
            if (i_module_en) begin
                if (i_ld) begin
                    count  <= i_ld_data;
                    reload <= i_ld_data;
                end else if (counted) begin
                    count <= count_step;
                end
                if (i_cmp_ld)
                    cmp <= i_cmp_data;

                if (counted && at_tc) begin
                    o_ovf       <= 1'b1;
                    o_ovf_pulse <= 1'b1;
                end else if (i_flag_clr) begin
                    o_ovf <= 1'b0;
                end

                if (counted && (count_step == cmp))
                    o_cmp_match <= 1'b1;
                else if (i_flag_clr)
                    o_cmp_match <= 1'b0;
            end
        end
    end

`ifdef COUNTER16_CAPTURE_EN
    logic cap_s1, cap_s2, cap_s3, cap_edge;

    assign cap_edge = cap_s2 && !cap_s3;

    // Capture runs even while the core is disabled so a frozen count can be sampled.
    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            cap_s1          <= 1'b0;
            cap_s2          <= 1'b0;
            cap_s3          <= 1'b0;
            o_capture_data  <= '0;
            o_capture_valid <= 1'b0;
        end else begin
            cap_s1 <= i_capture;
            cap_s2 <= cap_s1;
            cap_s3 <= cap_s2;
            if (cap_edge) begin
                o_capture_data  <= count;
                o_capture_valid <= 1'b1;
            end else if (i_module_en && i_flag_clr) begin
                o_capture_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_capture;

    assign unused_capture  = i_capture;
    assign o_capture_data  = '0;
    assign o_capture_valid = 1'b0;
`endif

endmodule

// File: tb/tb_counter16_core.sv
// tb/tb_counter16_core.sv - scoreboard-driven bench for counter16_core
module tb_counter16_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, tick, ld, cmp_ld, dir, start, stop, clr, cap;
    logic [15:0] ld_data, cmp_data;
    logic [1:0]  mode;
    logic [15:0] count, cap_data;
    logic        running, ovf, ovf_pulse, cmp_match, cap_valid;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    counter16_core #(.WIDTH(16)) dut (
        .i_sysclk(clk), .i_sysrst(rst), .i_module_en(en), .i_tick(tick),
        .i_ld(ld), .i_ld_data(ld_data), .i_cmp_ld(cmp_ld), .i_cmp_data(cmp_data),
        .i_mode(mode), .i_dir(dir), .i_start(start), .i_stop(stop),
        .i_flag_clr(clr), .i_capture(cap),
        .o_count(count), .o_running(running), .o_ovf(ovf), .o_ovf_pulse(ovf_pulse),
        .o_cmp_match(cmp_match), .o_capture_data(cap_data), .o_capture_valid(cap_valid)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
        tick = 0; ld = 0; cmp_ld = 0; start = 0; stop = 0; clr = 0;
    endtask

    task automatic test_reset;
        rst = 1; en = 1; tick = 0; ld = 0; cmp_ld = 0; start = 0; stop = 0;
        clr = 0; cap = 0; dir = 0; mode = 2'b00; ld_data = '0; cmp_data = '0;
        #60;
        vectors++;
        if ({count, running, ovf, ovf_pulse, cmp_match, cap_data, cap_valid} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_state got cnt=%h run=%b ovf=%b pls=%b cmp=%b cd=%h cv=%b exp all 0",
                     count, running, ovf, ovf_pulse, cmp_match, cap_data, cap_valid);
        end
        @(negedge clk); rst = 0;
        cyc;
    endtask

    task automatic test_load_run;
        ld = 1; ld_data = 16'h0005; mode = 2'b00; dir = 0; cyc;
        vectors++;
        if (count !== 16'h0005) begin miscompares++; $display("FAIL load got %h exp 0005", count); end
        start = 1; cyc;
        vectors++;
        if (running !== 1'b1) begin miscompares++; $display("FAIL start_running got %b exp 1", running); end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(16'(6 + i));
            tick = 1; cyc;
            e = exp_q.pop_front();
            vectors++;
            if (count !== e) begin miscompares++; $display("FAIL run_tick%0d got %h exp %h", i, count, e); end
        end
        vectors++;
        if ({ovf, ovf_pulse, cmp_match} !== 3'b000) begin
            miscompares++; $display("FAIL run_flags got %b%b%b exp 000", ovf, ovf_pulse, cmp_match);
        end
    endtask

    task automatic test_wrap;
        ld = 1; ld_data = 16'hFFFE; cyc;
        exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
        tick = 1; cyc;
        e = exp_q.pop_front();
        vectors++;
        if ({count, ovf_pulse, ovf} !== {e, 2'b00}) begin
            miscompares++; $display("FAIL wrap_pre got %h/%b/%b exp %h/0/0", count, ovf_pulse, ovf, e);
        end
        tick = 1; cyc;
        e = exp_q.pop_front();
        // compare register is still 0, so the wrap to 0 also matches
        vectors++;
        if ({count, ovf_pulse, ovf, cmp_match} !== {e, 3'b111}) begin
            miscompares++;
            $display("FAIL wrap got %h/%b/%b/%b exp %h/1/1/1", count, ovf_pulse, ovf, cmp_match, e);
        end
        cyc;
        vectors++;
        if ({ovf_pulse, ovf} !== 2'b01) begin
            miscompares++; $display("FAIL wrap_sticky got pls=%b ovf=%b exp 0/1", ovf_pulse, ovf);
        end
        clr = 1; cyc;
        vectors++;
        if ({ovf, cmp_match, running} !== 3'b001) begin
            miscompares++; $display("FAIL flag_clr got ovf=%b cmp=%b run=%b exp 0/0/1", ovf, cmp_match, running);
        end
    endtask

    task automatic test_reload;
        logic [15:0] seq [4] = '{16'h2, 16'h1, 16'h0, 16'h3};
        ld = 1; ld_data = 16'h0003; dir = 1; mode = 2'b01; cyc;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(seq[i]);
            tick = 1; cyc;
            e = exp_q.pop_front();
            vectors++;
            if (count !== e) begin miscompares++; $display("FAIL reload_tick%0d got %h exp %h", i, count, e); end
        end
        vectors++;
        if ({ovf, ovf_pulse} !== 2'b11) begin
            miscompares++; $display("FAIL reload_ovf got %b%b exp 11", ovf, ovf_pulse);
        end
        clr = 1; cyc;
    endtask

    task automatic test_oneshot;
        logic [15:0] seq [5] = '{16'hFFFE, 16'hFFFF, 16'hFFFD, 16'hFFFD, 16'hFFFD};
        ld = 1; ld_data = 16'hFFFD; dir = 0; mode = 2'b10; cyc;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(seq[i]);
            tick = 1; cyc;
            e = exp_q.pop_front();
            vectors++;
            if ({count, running} !== {e, (i < 2)}) begin
                miscompares++;
                $display("FAIL oneshot_tick%0d got %h run=%b exp %h run=%b", i, count, running, e, i < 2);
            end
        end
        vectors++;
        if (ovf !== 1'b1) begin miscompares++; $display("FAIL oneshot_ovf got %b exp 1", ovf); end
        start = 1; stop = 1; cyc;
        vectors++;
        if (running !== 1'b0) begin miscompares++; $display("FAIL stop_wins got %b exp 0", running); end
        clr = 1; cyc;
    endtask

    task automatic test_compare;
        cmp_ld = 1; cmp_data = 16'h0010; cyc;
        vectors++;
        if (cmp_match !== 1'b0) begin miscompares++; $display("FAIL cmp_ld_only got %b exp 0", cmp_match); end
        ld = 1; ld_data = 16'h000E; mode = 2'b00; dir = 0; start = 1; cyc;
        tick = 1; cyc;
        vectors++;
        if ({count, cmp_match} !== {16'h000F, 1'b0}) begin
            miscompares++; $display("FAIL cmp_pre got %h/%b exp 000f/0", count, cmp_match);
        end
        tick = 1; cyc;
        vectors++;
        if ({count, cmp_match} !== {16'h0010, 1'b1}) begin
            miscompares++; $display("FAIL cmp_hit got %h/%b exp 0010/1", count, cmp_match);
        end
        clr = 1; cmp_ld = 1; cmp_data = 16'h0011; cyc;
        tick = 1; clr = 1; cyc;
        vectors++;
        if ({count, cmp_match} !== {16'h0011, 1'b1}) begin
            miscompares++; $display("FAIL set_beats_clr got %h/%b exp 0011/1", count, cmp_match);
        end
        clr = 1; cyc;
    endtask

    task automatic test_ld_tick;
        ld = 1; ld_data = 16'hFFFF; cyc;
        ld = 1; ld_data = 16'h0007; tick = 1; cyc;
        vectors++;
        if ({count, ovf, ovf_pulse} !== {16'h0007, 2'b00}) begin
            miscompares++; $display("FAIL ld_beats_tick got %h/%b/%b exp 0007/0/0", count, ovf, ovf_pulse);
        end
    endtask

    task automatic test_enable;
        en = 0; tick = 1; stop = 1; cyc;
        vectors++;
        if ({count, running} !== {16'h0007, 1'b1}) begin
            miscompares++; $display("FAIL disabled_freeze got %h/%b exp 0007/1", count, running);
        end
        en = 1;
    endtask

    task automatic test_capture;
        ld = 1; ld_data = 16'h0042; cyc;
        en = 0; cap = 1;
        for (int i = 1; i <= 3; i++) begin
            cyc;
`ifdef COUNTER16_CAPTURE_EN
            e = (i == 3) ? 16'h0042 : 16'h0000;
            vectors++;
            if ({cap_valid, cap_data} !== {(i == 3), e}) begin
                miscompares++; $display("FAIL capture_c%0d got v=%b d=%h exp v=%b d=%h", i, cap_valid, cap_data, i == 3, e);
            end
`else
            vectors++;
            if ({cap_valid, cap_data} !== 17'd0) begin
                miscompares++; $display("FAIL capture_off_c%0d got v=%b d=%h exp 0/0000", i, cap_valid, cap_data);
            end
`endif
        end
        cap = 0; en = 1; clr = 1; cyc;
        vectors++;
        if (cap_valid !== 1'b0) begin miscompares++; $display("FAIL capture_clr got %b exp 0", cap_valid); end
    endtask

    task automatic test_reset_mid;
        ld = 1; ld_data = 16'h0100; cyc;
        tick = 1; #2; rst = 1; #1;
        vectors++;
        if ({count, running, ovf, cmp_match} !== 19'd0) begin
            miscompares++; $display("FAIL async_reset got %h/%b/%b/%b exp 0", count, running, ovf, cmp_match);
        end
        tick = 0;
        @(negedge clk); rst = 0;
        dir = 1; mode = 2'b01; start = 1; cyc;
        tick = 1; cyc;
        vectors++;
        if ({count, ovf} !== {16'h0000, 1'b1}) begin
            miscompares++; $display("FAIL reload_reg_reset got %h/%b exp 0000/1", count, ovf);
        end
    endtask

    initial begin
        test_reset;
        test_load_run;
        test_wrap;
        test_reload;
        test_oneshot;
        test_compare;
        test_ld_tick;
        test_enable;
        test_capture;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
